// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer writer and its pixel FIFO.
package fb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2
   } fb_state_t;

   typedef struct packed {
      logic [16:0] addr;
      logic [11:0] data;
   } fb_pixel_t;

   localparam logic [11:0] BG_COLOR_DEFAULT = 12'h000;

endpackage

// File: rtl/fb_pixel_fifo.sv
// Show-ahead FIFO of frame-buffer writes; the head entry is visible while not empty.
module fb_pixel_fifo
   import fb_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk_in,
   input  logic          rst_n_in,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  fb_pixel_t     wr_entry,
   output fb_pixel_t     rd_entry,
   output logic          empty,
   output logic [AW:0]   count
);

   fb_pixel_t       mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            full;
   logic            do_push;
   logic            do_pop;

   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign do_pop   = pop && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push  = push && (!full || do_pop);
   assign rd_entry = mem[rd_ptr];

   // NOTE: the storage array has no reset; pointers and count alone define what is valid.
   always_ff @(posedge clk_in) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/framebuffer_writer.sv
// Decimates the shaded pixel stream into frame-buffer writes, clearing the buffer at each frame start.
module framebuffer_writer
   import fb_pkg::*;
#(
   parameter int          FB_W       = 320,
   parameter int          FB_H       = 180,
   parameter int          SHIFT      = 2,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [11:0] BG_COLOR   = BG_COLOR_DEFAULT
) (
   input  logic          clk_in,
   input  logic          rst_n_in,
   input  logic          frame_start_in,
   input  logic [10:0]   x_in,
   input  logic [9:0]    y_in,
   input  logic          block_visible_in,
   input  logic [3:0]    r_in,
   input  logic [3:0]    g_in,
   input  logic [3:0]    b_in,
   input  logic          rgb_valid_in,
   output logic [16:0]   fb_addr_out,
   output logic [11:0]   fb_data_out,
   output logic          fb_we_out,
   input  logic          fb_ready_in,
   output logic          frame_done_out,
   output logic [15:0]   overflow_count_out,
   output logic          busy_out
);

   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam logic [16:0] LAST_ADDR = 17'(FB_W * FB_H - 1);

   fb_state_t     state;
   logic [16:0]   clr_cnt;

   logic [10:0]   x_dec;
   logic [9:0]    y_dec;
   logic          keep;
   logic          s1_valid;
   logic [10:0]   s1_x;
   logic [9:0]    s1_y;
   logic [11:0]   s1_data;
   logic          s2_valid;
   fb_pixel_t     s2_px;

   fb_pixel_t     head;
   logic          fifo_empty;
   logic [AW:0]   fifo_count;
   logic [AW+1:0] occupancy;
   logic          port_pixel;
   logic          pixel_accept;
   logic          port_free;
   logic          live;
   logic          has_room;
   logic          fifo_push;
   logic          fifo_pop;
   logic          drop;

   assign x_dec = x_in >> SHIFT;
   assign y_dec = y_in >> SHIFT;
   assign keep  = rgb_valid_in && (x_in[SHIFT-1:0] == '0) && (y_in[SHIFT-1:0] == '0)
                  && (x_dec < 11'(FB_W)) && (y_dec < 10'(FB_H));

   // NOTE: pipeline registers use non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_y     <= '0;
         s1_data  <= '0;
         s2_valid <= 1'b0;
         s2_px    <= '0;
      end else begin
         s1_valid     <= keep;
         s1_x         <= x_dec;
         s1_y         <= y_dec;
         s1_data      <= block_visible_in ? {r_in, g_in, b_in} : BG_COLOR;
         s2_valid     <= s1_valid;
         s2_px.addr   <= 17'(s1_y) * 17'(FB_W) + 17'(s1_x);
         s2_px.data   <= s1_data;
      end
   end

   // The entry sitting in the write port still owns its FIFO slot until it is accepted.
   assign port_pixel   = fb_we_out && (state == RUN);
   assign pixel_accept = port_pixel && fb_ready_in;
   assign occupancy    = {1'b0, fifo_count} + {{(AW+1){1'b0}}, port_pixel};
   assign has_room     = (occupancy < (AW+2)'(FIFO_DEPTH)) || pixel_accept;
   assign live         = s2_valid && (state != IDLE) && !frame_start_in;
   assign fifo_push    = live && has_room;
   assign drop         = live && !has_room;
   assign port_free    = !fb_we_out || fb_ready_in;
   assign fifo_pop     = (state == RUN) && !frame_start_in && port_free && !fifo_empty;

   fb_pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .flush    (frame_start_in),
      .push     (fifo_push),
      .pop      (fifo_pop),
      .wr_entry (s2_px),
      .rd_entry (head),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state              <= IDLE;
         clr_cnt            <= '0;
         fb_we_out          <= 1'b0;
         fb_addr_out        <= '0;
         fb_data_out        <= '0;
         frame_done_out     <= 1'b0;
         overflow_count_out <= '0;
         busy_out           <= 1'b0;
      end else begin
         frame_done_out <= pixel_accept && (fb_addr_out == LAST_ADDR) && !frame_start_in;
         if (drop && (overflow_count_out != 16'hFFFF)) begin
            overflow_count_out <= overflow_count_out + 1'b1;
         end

         if (frame_start_in) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            fb_we_out <= 1'b0;
            busy_out  <= 1'b1;
         end else begin
            case (state)
               CLEAR: begin
                  if (fb_we_out && fb_ready_in && (fb_addr_out == LAST_ADDR)) begin
                     state     <= RUN;
                     fb_we_out <= 1'b0;
                     busy_out  <= 1'b0;
                  end else if (port_free && (clr_cnt <= LAST_ADDR)) begin
                     fb_we_out   <= 1'b1;
                     fb_addr_out <= clr_cnt;
                     fb_data_out <= BG_COLOR;
                     clr_cnt     <= clr_cnt + 1'b1;
                  end
               end
               RUN: begin
                  if (port_free) begin
                     fb_we_out <= !fifo_empty;
                     if (!fifo_empty) begin
                        fb_addr_out <= head.addr;
                        fb_data_out <= head.data;
                     end
                  end
               end
               default: begin
                  fb_we_out <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed bench for framebuffer_writer: clear sweep, vector table in RUN, stall, frame done, restart, reset.
module tb_framebuffer_writer;

   localparam int          TOTAL = 57600;
   localparam logic [11:0] BG    = 12'h000;

   logic          clk_in = 1'b0;
   logic          rst_n_in;
   logic          frame_start_in;
   logic [10:0]   x_in;
   logic [9:0]    y_in;
   logic          block_visible_in;
   logic [3:0]    r_in, g_in, b_in;
   logic          rgb_valid_in;
   logic [16:0]   fb_addr_out;
   logic [11:0]   fb_data_out;
   logic          fb_we_out;
   logic          fb_ready_in;
   logic          frame_done_out;
   logic [15:0]   overflow_count_out;
   logic          busy_out;

   int errors = 0;
   int checks = 0;

   always #5 clk_in = ~clk_in;

   framebuffer_writer dut (
      .clk_in             (clk_in),
      .rst_n_in           (rst_n_in),
      .frame_start_in     (frame_start_in),
      .x_in               (x_in),
      .y_in               (y_in),
      .block_visible_in   (block_visible_in),
      .r_in               (r_in),
      .g_in               (g_in),
      .b_in               (b_in),
      .rgb_valid_in       (rgb_valid_in),
      .fb_addr_out        (fb_addr_out),
      .fb_data_out        (fb_data_out),
      .fb_we_out          (fb_we_out),
      .fb_ready_in        (fb_ready_in),
      .frame_done_out     (frame_done_out),
      .overflow_count_out (overflow_count_out),
      .busy_out           (busy_out)
   );

   typedef struct {
      logic [10:0] x;
      logic [9:0]  y;
      logic        vis;
      logic [11:0] rgb;
      logic        exp_write;
      logic [16:0] exp_addr;
      logic [11:0] exp_data;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      @(negedge clk_in);
   endtask

   task automatic drive_pixel(input logic [10:0] x, input logic [9:0] y, input logic vis,
                              input logic [11:0] rgb);
      x_in             = x;
      y_in             = y;
      block_visible_in = vis;
      {r_in, g_in, b_in} = rgb;
      rgb_valid_in     = 1'b1;
   endtask

   function automatic logic [11:0] stall_rgb(input int i);
      return {4'(i), 4'hC, 4'(15 - i)};
   endfunction

   initial begin
      int n, order_err, busy_err, fd_seen, first_k, wcount, unstable, got;
      logic have, hit, accepted;
      logic [16:0] got_addr, hold_addr;
      logic [11:0] got_data, hold_data;
      logic [15:0] ovf_before;

      vecs[0] = '{11'd8,    10'd4,   1'b1, 12'hA53, 1'b1, 17'd322, 12'hA53};
      vecs[1] = '{11'd9,    10'd4,   1'b1, 12'hFFF, 1'b0, 17'd0,   12'h000};
      vecs[2] = '{11'd1280, 10'd0,   1'b1, 12'hFFF, 1'b0, 17'd0,   12'h000};
      vecs[3] = '{11'd0,    10'd0,   1'b0, 12'hFFF, 1'b1, 17'd0,   BG};
      vecs[4] = '{11'd4,    10'd8,   1'b1, 12'h0F0, 1'b1, 17'd641, 12'h0F0};
      vecs[5] = '{11'd8,    10'd5,   1'b1, 12'h111, 1'b0, 17'd0,   12'h000};
      vecs[6] = '{11'd0,    10'd720, 1'b1, 12'h222, 1'b0, 17'd0,   12'h000};
      vecs[7] = '{11'd1276, 10'd0,   1'b1, 12'hF0F, 1'b1, 17'd319, 12'hF0F};

      rst_n_in = 1'b0;
      frame_start_in = 1'b0;
      rgb_valid_in = 1'b0;
      fb_ready_in = 1'b1;
      drive_pixel(11'd0, 10'd0, 1'b0, 12'h000);
      rgb_valid_in = 1'b0;
      repeat (3) @(negedge clk_in);
      rst_n_in = 1'b1;
      tick();
      check("reset_we", fb_we_out, 1'b0);
      check("reset_addr", fb_addr_out, 17'd0);
      check("reset_data", fb_data_out, 12'h000);
      check("reset_done", frame_done_out, 1'b0);
      check("reset_ovf", overflow_count_out, 16'd0);
      check("reset_busy", busy_out, 1'b0);

      // Full clear sweep with no pixels.
      frame_start_in = 1'b1;
      tick();
      frame_start_in = 1'b0;
      check("clear_busy_high", busy_out, 1'b1);
      n = 0; order_err = 0; busy_err = 0; fd_seen = 0;
      for (int c = 0; c < TOTAL + 100 && n < TOTAL; c++) begin
         if (frame_done_out) fd_seen++;
         if (fb_we_out && fb_ready_in) begin
            if (fb_addr_out != 17'(n) || fb_data_out != BG) order_err++;
            if (!busy_out) busy_err++;
            n++;
         end
         tick();
      end
      check("clear_count", n, TOTAL);
      check("clear_order", order_err, 0);
      check("clear_busy_during", busy_err, 0);
      check("clear_busy_after", busy_out, 1'b0);
      check("clear_we_after", fb_we_out, 1'b0);
      check("clear_no_done", fd_seen + int'(frame_done_out), 0);

      // Single pixels in RUN.
      for (int i = 0; i < 8; i++) begin
         ovf_before = overflow_count_out;
         drive_pixel(vecs[i].x, vecs[i].y, vecs[i].vis, vecs[i].rgb);
         tick();
         rgb_valid_in = 1'b0;
         first_k = 0; wcount = 0; got_addr = '0; got_data = '0;
         for (int k = 1; k <= 8; k++) begin
            tick();
            if (fb_we_out) begin
               if (first_k == 0) begin
                  first_k  = k;
                  got_addr = fb_addr_out;
                  got_data = fb_data_out;
               end
               wcount++;
            end
         end
         check($sformatf("vec%0d_writes", i), wcount, {31'd0, vecs[i].exp_write});
         if (vecs[i].exp_write) begin
            check($sformatf("vec%0d_latency", i), first_k, 3);
            check($sformatf("vec%0d_addr", i), got_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_data", i), got_data, vecs[i].exp_data);
         end
         check($sformatf("vec%0d_ovf", i), overflow_count_out, ovf_before);
      end

      // Stall: 40 cycles of no ready with 20 pixels streamed.
      fb_ready_in = 1'b0;
      have = 1'b0; unstable = 0; hold_addr = '0; hold_data = '0;
      for (int c = 0; c < 40; c++) begin
         if (c < 20) drive_pixel(11'(4 * c), 10'd8, 1'b1, stall_rgb(c));
         else rgb_valid_in = 1'b0;
         tick();
         if (fb_we_out) begin
            if (!have) begin
               have = 1'b1;
               hold_addr = fb_addr_out;
               hold_data = fb_data_out;
            end else if (fb_addr_out != hold_addr || fb_data_out != hold_data) begin
               unstable++;
            end
         end
      end
      check("stall_we_held", fb_we_out, 1'b1);
      check("stall_hold_addr", hold_addr, 17'd640);
      check("stall_hold_data", hold_data, stall_rgb(0));
      check("stall_stable", unstable, 0);
      check("stall_overflow", overflow_count_out, 16'd4);
      fb_ready_in = 1'b1;
      got = 0; order_err = 0;
      for (int c = 0; c < 40; c++) begin
         if (fb_we_out && fb_ready_in) begin
            if (fb_addr_out != 17'(640 + got) || fb_data_out != stall_rgb(got)) order_err++;
            got++;
         end
         tick();
      end
      check("drain_count", got, 16);
      check("drain_order", order_err, 0);

      // Last buffer address triggers frame_done one cycle after acceptance.
      drive_pixel(11'd1276, 10'd716, 1'b1, 12'h123);
      tick();
      rgb_valid_in = 1'b0;
      accepted = 1'b0; fd_seen = 0;
      for (int k = 0; k < 8 && !accepted; k++) begin
         if (frame_done_out) fd_seen++;
         if (fb_we_out && fb_ready_in && fb_addr_out == 17'd57599) begin
            accepted = 1'b1;
            check("last_data", fb_data_out, 12'h123);
            tick();
            check("frame_done_pulse", frame_done_out, 1'b1);
            tick();
            check("frame_done_single", frame_done_out, 1'b0);
         end else begin
            tick();
         end
      end
      check("last_accepted", accepted, 1'b1);
      check("frame_done_not_early", fd_seen, 0);

      // Asynchronous reset with a stalled write pending.
      fb_ready_in = 1'b0;
      drive_pixel(11'd8, 10'd4, 1'b1, 12'hA53);
      tick();
      rgb_valid_in = 1'b0;
      for (int k = 0; k < 8 && !fb_we_out; k++) tick();
      check("pre_reset_we", fb_we_out, 1'b1);
      #2;
      rst_n_in = 1'b0;
      #1;
      check("async_rst_we", fb_we_out, 1'b0);
      check("async_rst_addr", fb_addr_out, 17'd0);
      check("async_rst_data", fb_data_out, 12'h000);
      check("async_rst_ovf", overflow_count_out, 16'd0);
      check("async_rst_busy", busy_out, 1'b0);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      fb_ready_in = 1'b1;

      // IDLE ignores pixels.
      drive_pixel(11'd8, 10'd4, 1'b1, 12'hA53);
      tick();
      rgb_valid_in = 1'b0;
      wcount = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (fb_we_out) wcount++;
      end
      check("idle_no_write", wcount, 0);

      // frame_start mid-clear with queued pixels restarts the sweep.
      frame_start_in = 1'b1;
      tick();
      frame_start_in = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 1500 && !hit; c++) begin
         if (fb_we_out && fb_ready_in && fb_addr_out == 17'd1000) begin
            hit = 1'b1;
         end else begin
            if (c < 3) drive_pixel(11'(4 * c), 10'd0, 1'b1, 12'h5A5);
            else rgb_valid_in = 1'b0;
            tick();
         end
      end
      rgb_valid_in = 1'b0;
      check("mid_clear_reached", hit, 1'b1);
      check("fifo_queued", 32'(dut.u_fifo.count), 3);
      frame_start_in = 1'b1;
      tick();
      frame_start_in = 1'b0;
      check("fifo_flushed", 32'(dut.u_fifo.count), 0);
      check("restart_busy", busy_out, 1'b1);
      got = 0; order_err = 0;
      for (int c = 0; c < 10 && got < 3; c++) begin
         if (fb_we_out && fb_ready_in) begin
            if (fb_addr_out != 17'(got) || fb_data_out != BG) order_err++;
            got++;
         end
         tick();
      end
      check("restart_count", got, 3);
      check("restart_order", order_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
